pcie_rq_arbiter: RTL and testbench

Packet-granular 2:1 arbiter that shares the PCIe Requester Request (RQ) AXI-stream between two sources: the user-logic RQ stream and the ATS invalidation-completion stream from the CQ snooper.
- Grants are held for a whole TLP and change only at tlast boundaries, so beats from the two sources never interleave.
- Sits between both RQ sources and the PCIe hard block RQ interface.
- Provides per-source packet counters and a runaway-packet length check for ILA debug.

---
 rtl/pcie_rq_arbiter_if.sv | 31 +++
 rtl/pcie_rq_arbiter.sv | 127 ++++++++++++
 tb/tb_pcie_rq_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_rq_arbiter_if.sv
// AXI-stream bundle shared by the RQ arbiter's two source ports and its PCIe-facing master port.
// The ATS source leaves tuser undriven-by-design on the arbiter side; it is carried only for symmetry.
interface pcie_rq_arbiter_if #(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 137
);
    logic [AXIS_DATA_WIDTH-1:0]   tdata;
    logic [AXIS_DATA_WIDTH/8-1:0] tkeep;
    logic [AXIS_TUSER_WIDTH-1:0]  tuser;
    logic                         tlast;
    logic                         tvalid;
    logic                         tready;

    modport master (
        output tdata,
        output tkeep,
        output tuser,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tuser,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/pcie_rq_arbiter.sv
// Packet-granular 2:1 arbiter: user RQ stream and ATS invalidation completions onto the PCIe RQ port.
// Optional build macro RQ_ARB_ATS_PRIO_EN gives ATS strict priority instead of round-robin.
module pcie_rq_arbiter #(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 137,
    parameter int MAX_BEATS        = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    pcie_rq_arbiter_if.slave         s_usr,
    pcie_rq_arbiter_if.slave         s_ats,
    pcie_rq_arbiter_if.master        m,
    input  logic                     clr_stats,
    output logic                     gnt_ats,
    output logic [15:0]              usr_pkt_cnt,
    output logic [15:0]              ats_pkt_cnt,
    output logic                     err_len
);
    localparam int BCW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_USR = 2'd1,
        GNT_ATS = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           last_ats;
    logic [BCW-1:0] beat_cnt;
    logic           beat_hs;
    logic           pkt_end;
    logic           prefer_idle;
    logic           prefer_eop;
    logic           unused_ats_tuser;

    // Contention goes to the preferred source; a lone valid source always wins.
    function automatic state_t arb(input logic usr_v, input logic ats_v, input logic prefer_ats);
        if (usr_v && ats_v) return prefer_ats ? GNT_ATS : GNT_USR;
        if (ats_v)          return GNT_ATS;
        if (usr_v)          return GNT_USR;
        return IDLE;
    endfunction

`ifdef RQ_ARB_ATS_PRIO_EN
    assign prefer_idle = 1'b1;
    assign prefer_eop  = 1'b1;
`else
    // At tlast the other source is preferred, which also covers "same source if only it is valid".
    assign prefer_idle = ~last_ats;
    assign prefer_eop  = (state == GNT_USR);
`endif

    assign unused_ats_tuser = ^s_ats.tuser;

    always_comb begin
        state_nxt    = state;
        m.tdata      = '0;
        m.tkeep      = '0;
        m.tuser      = '0;
        m.tlast      = 1'b0;
        m.tvalid     = 1'b0;
        s_usr.tready = 1'b0;
        s_ats.tready = 1'b0;
        gnt_ats      = 1'b0;
        beat_hs      = 1'b0;
        pkt_end      = 1'b0;

        case (state)
            GNT_USR: begin
                m.tdata      = s_usr.tdata;
                m.tkeep      = s_usr.tkeep;
                m.tuser      = s_usr.tuser;
                m.tlast      = s_usr.tlast;
                m.tvalid     = s_usr.tvalid;
                s_usr.tready = m.tready;
            end
            GNT_ATS: begin
                m.tdata      = s_ats.tdata;
                m.tkeep      = s_ats.tkeep;
                m.tlast      = s_ats.tlast;
                m.tvalid     = s_ats.tvalid;
                s_ats.tready = m.tready;
                gnt_ats      = 1'b1;
            end
            default: ;
        endcase

        beat_hs = m.tvalid & m.tready;
        pkt_end = beat_hs & m.tlast;

        if (state == IDLE) begin
            state_nxt = arb(s_usr.tvalid, s_ats.tvalid, prefer_idle);
        end else if (pkt_end) begin
            state_nxt = arb(s_usr.tvalid, s_ats.tvalid, prefer_eop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_ats <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (pkt_end) begin
                last_ats <= (state == GNT_ATS);
                beat_cnt <= '0;
            end else if (beat_hs && (beat_cnt != BCW'(MAX_BEATS))) begin
                beat_cnt <= beat_cnt + BCW'(1);
            end
        end
    end

    // A clear in the same cycle as a completing tlast wins over the increment.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            usr_pkt_cnt <= '0;
            ats_pkt_cnt <= '0;
            err_len     <= 1'b0;
        end else begin
            if (pkt_end && (state == GNT_USR)) usr_pkt_cnt <= usr_pkt_cnt + 16'd1;
            if (pkt_end && (state == GNT_ATS)) ats_pkt_cnt <= ats_pkt_cnt + 16'd1;
            if (beat_hs && !m.tlast && (beat_cnt == BCW'(MAX_BEATS - 1))) err_len <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// Bench for pcie_rq_arbiter: directed vector table, round-robin run, and a randomized run
// against a packet-level reference model.
module tb_pcie_rq_arbiter;
    localparam int DW = 64;
    localparam int UW = 8;
    localparam int KW = DW / 8;
    localparam int MB = 4;

    typedef struct {
        logic        rst, clr, uv, ul, av, al, mr;
        int          src;
        logic [15:0] ucnt, acnt;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_stats = 1'b0;
    logic        gnt_ats, err_len;
    logic [15:0] usr_pkt_cnt, ats_pkt_cnt;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tbl[$];

    pcie_rq_arbiter_if #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW)) usr_if ();
    pcie_rq_arbiter_if #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW)) ats_if ();
    pcie_rq_arbiter_if #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW)) m_if ();

    pcie_rq_arbiter #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst(rst), .s_usr(usr_if), .s_ats(ats_if), .m(m_if),
        .clr_stats(clr_stats), .gnt_ats(gnt_ats), .usr_pkt_cnt(usr_pkt_cnt),
        .ats_pkt_cnt(ats_pkt_cnt), .err_len(err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t row(input logic r, c, uv, ul, av, al, mr, input int src,
                                 input int uc, ac, input logic e);
        vec_t v;
        v.rst = r; v.clr = c; v.uv = uv; v.ul = ul; v.av = av; v.al = al; v.mr = mr;
        v.src = src; v.ucnt = 16'(uc); v.acnt = 16'(ac); v.err = e;
        return v;
    endfunction

    task automatic drive(input logic uv, ul, av, al, mr, input int tag);
        usr_if.tvalid = uv;
        usr_if.tlast  = ul;
        usr_if.tdata  = {32'hA5A5_0000, 32'(tag)};
        usr_if.tkeep  = 8'hF0 | 8'(tag & 15);
        usr_if.tuser  = 8'h40 + 8'(tag);
        ats_if.tvalid = av;
        ats_if.tlast  = al;
        ats_if.tdata  = {32'hB6B6_0000, 32'(tag)};
        ats_if.tkeep  = 8'h0F;
        ats_if.tuser  = 8'hEE;
        m_if.tready   = mr;
    endtask

    // src: 0 = nobody granted, 1 = user, 2 = ATS
    task automatic check_all(input string tag, input int src, input logic [15:0] eu,
                             input logic [15:0] ea, input logic ee);
        logic          ev, el, eur, ear;
        logic [DW-1:0] ed;
        logic [KW-1:0] ek;
        logic [UW-1:0] eus;
        ev = 1'b0; el = 1'b0; ed = '0; ek = '0; eus = '0;
        eur = (src == 1) && m_if.tready;
        ear = (src == 2) && m_if.tready;
        if (src == 1) begin
            ev = usr_if.tvalid; el = usr_if.tlast; ed = usr_if.tdata; ek = usr_if.tkeep;
            eus = usr_if.tuser;
        end else if (src == 2) begin
            ev = ats_if.tvalid; el = ats_if.tlast; ed = ats_if.tdata; ek = ats_if.tkeep;
        end
        chk({tag, "_m_tvalid"}, 64'(m_if.tvalid), 64'(ev));
        chk({tag, "_m_tlast"}, 64'(m_if.tlast), 64'(el));
        chk({tag, "_m_tdata"}, 64'(m_if.tdata), 64'(ed));
        chk({tag, "_m_tkeep"}, 64'(m_if.tkeep), 64'(ek));
        chk({tag, "_m_tuser"}, 64'(m_if.tuser), 64'(eus));
        chk({tag, "_usr_tready"}, 64'(usr_if.tready), 64'(eur));
        chk({tag, "_ats_tready"}, 64'(ats_if.tready), 64'(ear));
        chk({tag, "_gnt_ats"}, 64'(gnt_ats), 64'(src == 2));
        chk({tag, "_usr_pkt_cnt"}, 64'(usr_pkt_cnt), 64'(eu));
        chk({tag, "_ats_pkt_cnt"}, 64'(ats_pkt_cnt), 64'(ea));
        chk({tag, "_err_len"}, 64'(err_len), 64'(ee));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; clr_stats = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Source to serve next (-1 none, 0 user, 1 ATS); cur is the source finishing a TLP, -1 from idle.
    function automatic int pick(input bit uv, input bit av, input int cur, input bit last_was_ats);
`ifdef RQ_ARB_ATS_PRIO_EN
        if (av) return 1;
        if (uv) return 0;
        return -1;
`else
        bit v[2];
        v[0] = uv; v[1] = av;
        if (cur < 0) begin
            if (uv && av) return last_was_ats ? 0 : 1;
            if (av) return 1;
            if (uv) return 0;
            return -1;
        end
        if (v[1 - cur]) return 1 - cur;
        if (v[cur]) return cur;
        return -1;
`endif
    endfunction

    initial begin
        int            n, owner, nxt, nl;
        bit            last_ats, merr, hs;
        logic [15:0]   mu, ma;
        int            rem[2];
        bit            v[2];
        logic [DW-1:0] rd[2];
        logic [KW-1:0] rk[2];
        logic [UW-1:0] ru[2];

        //              rst clr uv ul av al mr src ucnt acnt err
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0)); // single user TLP, 3 beats
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(row(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0)); // reset, then simultaneous start
        tbl.push_back(row(0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 1, 1, 1, 2, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(row(0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0)); // non-interleave, tready toggling
        tbl.push_back(row(0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 0));
        tbl.push_back(row(0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 0));
        tbl.push_back(row(0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 0));
        tbl.push_back(row(0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 0));
        tbl.push_back(row(0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 1, 1, 1, 2, 2, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 2, 2, 2, 0));
        tbl.push_back(row(0, 1, 0, 0, 0, 0, 1, 2, 2, 2, 0)); // clr_stats
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        tbl.push_back(row(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0)); // length error, 5 non-tlast beats
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(row(0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(row(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0)); // reset during beat 2 of 3
        tbl.push_back(row(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 1, 1, 1, 2, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0));

        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rst = tbl[i].rst;
            clr_stats = tbl[i].clr;
            drive(tbl[i].uv, tbl[i].ul, tbl[i].av, tbl[i].al, tbl[i].mr, i);
            @(negedge clk);
            check_all($sformatf("row%0d", i), tbl[i].src, tbl[i].ucnt, tbl[i].acnt, tbl[i].err);
        end

        // Both sources continuously offering 1-beat TLPs
        do_reset();
        drive(1, 1, 1, 1, 1, 0);
        n = 0;
        for (int c = 0; c < 80 && n < 20; c++) begin
            @(negedge clk);
            if (m_if.tvalid && m_if.tready) begin
`ifdef RQ_ARB_ATS_PRIO_EN
                chk($sformatf("rr_pkt%0d_gnt_ats", n), 64'(gnt_ats), 64'(1));
`else
                chk($sformatf("rr_pkt%0d_gnt_ats", n), 64'(gnt_ats), 64'(n % 2 == 0));
`endif
                n++;
            end
        end
        chk("rr_pkt_total", 64'(n), 64'(20));
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
`ifdef RQ_ARB_ATS_PRIO_EN
        chk("rr_usr_pkt_cnt", 64'(usr_pkt_cnt), 64'(0));
        chk("rr_ats_pkt_cnt", 64'(ats_pkt_cnt), 64'(20));
`else
        chk("rr_usr_pkt_cnt", 64'(usr_pkt_cnt), 64'(10));
        chk("rr_ats_pkt_cnt", 64'(ats_pkt_cnt), 64'(10));
`endif

        // Randomized traffic against the packet-level model
        do_reset();
        owner = -1; last_ats = 1'b0; mu = '0; ma = '0; merr = 1'b0; nl = 0;
        rem[0] = 0; rem[1] = 0; v[0] = 1'b0; v[1] = 1'b0;
        rd[0] = '0; rd[1] = '0; rk[0] = '0; rk[1] = '0; ru[0] = '0; ru[1] = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int s = 0; s < 2; s++) begin
                if (!v[s] && ($urandom_range(0, 9) < 6)) begin
                    if (rem[s] == 0) rem[s] = $urandom_range(1, 6);
                    v[s]  = 1'b1;
                    rd[s] = {$urandom, $urandom};
                    rk[s] = KW'($urandom);
                    ru[s] = UW'($urandom);
                end
            end
            usr_if.tvalid = v[0]; usr_if.tlast = (rem[0] == 1);
            usr_if.tdata = rd[0]; usr_if.tkeep = rk[0]; usr_if.tuser = ru[0];
            ats_if.tvalid = v[1]; ats_if.tlast = (rem[1] == 1);
            ats_if.tdata = rd[1]; ats_if.tkeep = rk[1]; ats_if.tuser = ru[1];
            m_if.tready = ($urandom_range(0, 9) < 7);
            clr_stats   = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            check_all($sformatf("rnd%0d", cyc), owner + 1, mu, ma, merr);

            hs  = (owner >= 0) && v[owner] && m_if.tready;
            nxt = owner;
            if (owner < 0) begin
                nxt = pick(v[0], v[1], -1, last_ats);
            end else if (hs && (rem[owner] == 1)) begin
                if (owner == 0) mu = mu + 16'd1;
                else            ma = ma + 16'd1;
                last_ats = (owner == 1);
                nl = 0;
                nxt = pick(v[0], v[1], owner, last_ats);
            end else if (hs) begin
                nl++;
                if (nl == MB) merr = 1'b1;
            end
            if (clr_stats) begin
                mu = '0; ma = '0; merr = 1'b0;
            end
            if (hs) begin
                v[owner] = 1'b0;
                rem[owner]--;
            end
            owner = nxt;
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
